// File: rtl/scan_driver.sv
// Display scan controller: walks five mux slots at a fixed dwell, blanks the
// start of each slot, and drives registered segment/digit outputs.
module scan_driver #(
  parameter int DIV   = 1000,
  parameter int BLANK = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] data_in,
  output logic [3:0] adress,
  output logic [7:0] seg,
  output logic [4:0] digit,
  output logic       frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [2:0]    slot_reg;
  logic [CW-1:0] cnt_reg;
  logic [7:0]    seg_reg;
  logic [4:0]    digit_reg;
  logic          frame_tick_reg;
  logic [4:0]    slot_onehot;
  logic          show;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_onehot
      assign slot_onehot[gi] = (slot_reg == 3'(gi));
    end
  endgenerate

  // Slot 0 maps to the mux default input, so the select is the upper four bits.
  assign adress = slot_onehot[4:1];

  generate
    if (BLANK == 0) begin : g_noblank
      assign show = 1'b1;
    end else begin : g_blank
      assign show = (cnt_reg >= CW'(BLANK));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg       <= 3'd0;
      cnt_reg        <= '0;
      seg_reg        <= 8'h00;
      digit_reg      <= 5'b00000;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= en && (slot_reg == 3'd4) && (cnt_reg == CNT_LAST);
      if (en) begin
        if (cnt_reg == CNT_LAST) begin
          cnt_reg  <= '0;
          slot_reg <= (slot_reg == 3'd4) ? 3'd0 : slot_reg + 3'd1;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end
      // Outputs lag the (slot, cnt) state by one edge.
      if (en && show) begin
        seg_reg   <= data_in;
        digit_reg <= slot_onehot;
      end else begin
        seg_reg   <= 8'h00;
        digit_reg <= 5'b00000;
      end
    end
  end

  assign seg        = seg_reg;
  assign digit      = digit_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_scan_driver.sv
// Directed bench for scan_driver: one instance at DIV=4/BLANK=1 with a mux
// model, one at DIV=2/BLANK=0 with directly driven data.
module tb_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en;
  logic [7:0] data_in;
  logic [3:0] adress;
  logic [7:0] seg;
  logic [4:0] digit;
  logic       frame_tick;

  logic       rst2, en2;
  logic [7:0] data2;
  logic [3:0] adress2;
  logic [7:0] seg2;
  logic [4:0] digit2;
  logic       frame_tick2;

  int total = 0;
  int bad   = 0;
  int pos;

  localparam logic [7:0] MUX_TAB [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  scan_driver #(.DIV(4), .BLANK(1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in),
    .adress(adress), .seg(seg), .digit(digit), .frame_tick(frame_tick)
  );

  scan_driver #(.DIV(2), .BLANK(0)) u_dut2 (
    .clk(clk), .rst(rst2), .en(en2), .data_in(data2),
    .adress(adress2), .seg(seg2), .digit(digit2), .frame_tick(frame_tick2)
  );

  // Five-input display mux, slot 0 on the default branch.
  always_comb begin
    case (adress)
      4'b0001: data_in = MUX_TAB[1];
      4'b0010: data_in = MUX_TAB[2];
      4'b0100: data_in = MUX_TAB[3];
      4'b1000: data_in = MUX_TAB[4];
      default: data_in = MUX_TAB[0];
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pos is the position inside a 20-cycle frame: slot = pos/4, cnt = pos%4.
  task automatic step(input string tag);
    logic [4:0] e_dig;
    logic [7:0] e_seg;
    logic       e_tick;
    logic [3:0] e_adr;
    e_dig  = 5'b0;
    e_seg  = 8'h00;
    e_tick = 1'b0;
    if (en) begin
      if (pos % 4 >= 1) begin
        e_dig = 5'(1 << (pos / 4));
        e_seg = MUX_TAB[pos / 4];
      end
      e_tick = (pos == 19);
    end
    tick();
    if (en) pos = (pos + 1) % 20;
    e_adr = (pos < 4) ? 4'b0000 : 4'(1 << (pos / 4 - 1));
    $display("%s pos=%0d adress=%b digit=%b seg=%h tick=%b", tag, pos, adress, digit, seg, frame_tick);
    check({tag, "_adr"},  32'(adress),     32'(e_adr));
    check({tag, "_dig"},  32'(digit),      32'(e_dig));
    check({tag, "_seg"},  32'(seg),        32'(e_seg));
    check({tag, "_tick"}, 32'(frame_tick), 32'(e_tick));
  endtask

  task automatic check_reset1(input string tag);
    check({tag, "_adr"},  32'(adress),     32'h0);
    check({tag, "_dig"},  32'(digit),      32'h0);
    check({tag, "_seg"},  32'(seg),        32'h0);
    check({tag, "_tick"}, 32'(frame_tick), 32'h0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1;
    rst2 = 1'b1; en2 = 1'b0; data2 = 8'h00;
    pos = 0;

    for (int i = 0; i < 3; i++) begin
      tick();
      $display("reset cycle %0d adress=%b digit=%b seg=%h", i, adress, digit, seg);
      check_reset1("reset");
    end
    rst = 1'b0;

    repeat (60) step("frame");

    repeat (10) step("adv");
    check("pre_freeze_adr", 32'(adress), 32'h2);
    en = 1'b0;
    repeat (5) step("freeze");
    en = 1'b1;
    repeat (3) step("resume");

    // Now in slot 3, cnt 1.
    rst = 1'b1;
    tick();
    $display("midreset adress=%b digit=%b seg=%h", adress, digit, seg);
    check_reset1("midreset");
    rst = 1'b0;
    pos = 0;
    repeat (4) step("restart");

    // BLANK=0, DIV=2 instance.
    en2 = 1'b1;
    tick();
    $display("r2 reset adress=%b digit=%b seg=%h", adress2, digit2, seg2);
    check("r2_rst_dig", 32'(digit2), 32'h0);
    check("r2_rst_seg", 32'(seg2),   32'h0);
    rst2 = 1'b0;
    data2 = 8'h11;
    tick();
    $display("r2 e1 adress=%b digit=%b seg=%h", adress2, digit2, seg2);
    check("r2_e1_dig", 32'(digit2),  32'h01);
    check("r2_e1_seg", 32'(seg2),    32'h11);
    check("r2_e1_adr", 32'(adress2), 32'h0);
    tick();
    $display("r2 e2 adress=%b digit=%b seg=%h", adress2, digit2, seg2);
    check("r2_e2_dig", 32'(digit2),  32'h01);
    check("r2_e2_adr", 32'(adress2), 32'h1);
    data2 = 8'h22;
    tick();
    $display("r2 e3 adress=%b digit=%b seg=%h", adress2, digit2, seg2);
    check("r2_e3_dig", 32'(digit2),  32'h02);
    check("r2_e3_seg", 32'(seg2),    32'h22);
    check("r2_e3_adr", 32'(adress2), 32'h1);
    data2 = 8'h2A;
    tick();
    $display("r2 e4 adress=%b digit=%b seg=%h", adress2, digit2, seg2);
    check("r2_e4_dig", 32'(digit2),  32'h02);
    check("r2_e4_seg", 32'(seg2),    32'h2A);
    check("r2_e4_adr", 32'(adress2), 32'h2);
    for (int i = 0; i < 6; i++) begin
      tick();
      $display("r2 e%0d digit=%b tick=%b", i + 5, digit2, frame_tick2);
      check("r2_nonzero", 32'(digit2 != 5'b0),   32'h1);
      check("r2_tick",    32'(frame_tick2),      32'(i == 5));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_driver.md
Name: scan_driver

Overview:
- Display scan controller that drives the one-hot `adress` select of the 5-input display data mux and consumes the mux's 8-bit `out` on `data_in`.
- Steps through the 5 mux slots in a fixed order at a programmable rate and inserts a blanking gap at the start of each slot to prevent ghosting.
- Drives registered segment and one-hot digit-enable outputs to the display pins.
- Emits a one-cycle pulse at the end of every full scan frame.

Parameters:
- DIV, 1000, clock cycles per slot (dwell time); legal range DIV >= 2.
- BLANK, 2, blanking cycles at the start of each slot; legal range 0 <= BLANK < DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  scan enable; 0 freezes the scan and blanks the display.
- data_in  input  8  segment data returned by the mux for the current `adress`.
- adress  output  4  one-hot slot select to the mux.
- seg  output  8  registered segment drive, active-high.
- digit  output  5  registered one-hot digit enable, active-high; bit k = slot k.
- frame_tick  output  1  one-cycle pulse at the end of slot 4.

Behaviour:
- One clock. Reset is synchronous and active-high; clock and reset are `clk` and `rst`.
- State:
  - `slot` register, range 0..4.
  - `cnt` register, range 0..DIV-1, width clog2(DIV).
- Reset, applied on the rising edge while rst=1, including mid-scan: slot=0, cnt=0, adress=4'b0000, seg=8'h00, digit=5'b00000, frame_tick=0.
- `adress` is a pure decode of the `slot` register and changes on the same edge as `slot`:
  - slot0 -> 0000, slot1 -> 0001, slot2 -> 0010, slot3 -> 0100, slot4 -> 1000.
  - Slot0 therefore selects the mux default input.
- Counters (en=1):
  - cnt increments by 1 each cycle.
  - When cnt==DIV-1: cnt <= 0 and slot <= slot+1.
  - slot wraps 4 -> 0.
- frame_tick: registered. It is 1 for exactly one cycle, on the edge where slot==4, cnt==DIV-1 and en=1. Otherwise it is 0.
- Outputs are registered, with one cycle of lag behind the (slot, cnt) state. On each edge:
  - If en=1 and cnt >= BLANK: seg <= data_in and digit <= onehot(slot).
  - Otherwise: seg <= 0 and digit <= 0.
- Each slot therefore shows exactly BLANK blank cycles followed by DIV-BLANK driven cycles. BLANK=0 gives no gap.
- `seg` samples `data_in` every driven cycle, so changes on the mux inputs propagate within a slot with one cycle of latency.
- en=0:
  - slot and cnt hold their values; adress holds.
  - seg and digit go to 0 on the next edge; frame_tick=0.
  - On en returning to 1, the scan resumes from the held (slot, cnt) with no restart, and the blanking rule applies from the held cnt.
- Simultaneous rst=1 and en=1: rst wins.
- digit is never multi-hot. seg is 0 whenever digit is 0.

Test Plan:
- Reset value: hold rst=1 for 3 cycles with en=1 -> adress=0000, seg=00, digit=00000, frame_tick=0 after the first edge.
- Full frame (DIV=4, BLANK=1; mux model with in0..in4 = 11,22,33,44,55; en=1):
  - adress sequence 0000,0001,0010,0100,1000, each held 4 cycles.
  - digit per slot: 1 cycle of 00000 followed by 3 cycles of the one-hot bit; seg = 11, 22, 33, 44, 55 respectively during the driven cycles.
  - frame_tick pulses once every 20 cycles.
- Wrap: run 3 frames -> slot returns to 0 after slot4 and adress returns to 0000; frame_tick spacing is exactly 20 cycles.
- Enable freeze: drop en in slot2 at cnt=2 for 5 cycles -> adress stays 0010, seg=00 and digit=00000 from the next edge, no frame_tick. On re-enable, slot2 completes its remaining cycles.
- Mid-scan reset: assert rst in slot3 at cnt=1 -> next edge returns all outputs to reset values and adress=0000; the scan restarts from slot0 with cnt=0.
- BLANK=0, DIV=2: no blank cycles; digit is non-zero on every cycle after the first post-reset edge; data_in changed mid-slot (22 -> 2A) appears on seg one cycle later.
